instr_fetch_unit: RTL and testbench

//  Fetch stage of the multicycle MIPS CPU; sits directly downstream of the instruction ROM.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle MIPS CPU.
// Owns the program counter, drives the instruction ROM, latches the fetched
// word into the instruction register and offers it to decode. Misaligned or
// out-of-range fetch addresses park the unit in a sticky fault state.
//
// Handshake: ir_valid && ir_ready on a rising edge transfers ir_out/pc_out to
// decode. While ir_valid is high, ir_out and pc_out do not change, and ir_valid
// only drops after a transfer, a redirect or a reset.
module instr_fetch_unit #(
    parameter int ROM_LAT   = 1,
    parameter int ROM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] start_pc,
    output logic [31:0] rom_addr,
    output logic        rom_read_en,
    input  logic [31:0] rom_instr,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Counter wide enough to count 0 .. ROM_LAT-1 cycles of a ROM request.
    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ROM_LAT - 1);

    state_t        state, state_d;
    logic [31:0]   pc, pc_d;
    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic          load_ir;

    // A fetch is legal when word aligned and the whole word lies inside the ROM.
    // The 33-bit sum keeps addresses near 2^32 from wrapping into range.
    function automatic logic fetch_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (({1'b0, addr} + 33'd3) < 33'(ROM_BYTES));
    endfunction

    // Next-state, next-pc and wait-counter logic; redirect outranks sequencing.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        wait_cnt_d = wait_cnt;
        load_ir    = 1'b0;
        case (state)
            S_IDLE: begin
                pc_d       = start_pc;
                wait_cnt_d = '0;
                state_d    = fetch_legal(start_pc) ? S_REQ : S_FAULT;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    wait_cnt_d = '0;
                    state_d    = fetch_legal(redirect_pc) ? S_REQ : S_FAULT;
                end else if (wait_cnt == LAST_CNT) begin
                    load_ir    = 1'b1;
                    pc_d       = pc + 32'd4;
                    wait_cnt_d = '0;
                    state_d    = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                // With ir_ready low a redirect simply discards the held word.
                if (redirect) begin
                    pc_d       = redirect_pc;
                    wait_cnt_d = '0;
                    state_d    = fetch_legal(redirect_pc) ? S_REQ : S_FAULT;
                end else if (ir_ready) begin
                    wait_cnt_d = '0;
                    state_d    = fetch_legal(pc) ? S_REQ : S_FAULT;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pc, counter and instruction register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            wait_cnt <= '0;
            ir_out   <= '0;
            pc_out   <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            wait_cnt <= wait_cnt_d;
            if (load_ir) begin
                ir_out <= rom_instr;
                pc_out <= pc;
            end
        end
    end

    // Outputs decoded from the state; the ROM address is always word aligned.
    always_comb begin
        rom_addr    = {pc[31:2], 2'b00};
        rom_read_en = (state == S_REQ);
        ir_valid    = (state == S_HOLD);
        fetch_err   = (state == S_FAULT);
        pc_plus4    = pc_out + 32'd4;
        state_dbg   = state;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: one instance with a single-cycle ROM and one with
// a three-cycle ROM, both fed from the same ROM image.
module tb_instr_fetch_unit;

    logic clk;

    // Instance a: ROM_LAT = 1
    logic        rst_a, rd_en_a, ir_valid_a, ir_ready_a, redirect_a, fetch_err_a;
    logic [31:0] start_pc_a, rom_addr_a, rom_instr_a, ir_out_a, pc_out_a, pc_plus4_a, redirect_pc_a;
    logic [1:0]  state_a;

    // Instance b: ROM_LAT = 3
    logic        rst_b, rd_en_b, ir_valid_b, ir_ready_b, redirect_b, fetch_err_b;
    logic [31:0] start_pc_b, rom_addr_b, rom_instr_b, ir_out_b, pc_out_b, pc_plus4_b, redirect_pc_b;
    logic [1:0]  state_b;

    logic [31:0] rom [0:31];
    logic [63:0] exp_qa[$];
    logic [63:0] exp_qb[$];
    logic [63:0] ea, eb;
    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit #(.ROM_LAT(1), .ROM_BYTES(128)) dut_a (
        .clk(clk), .rst(rst_a), .start_pc(start_pc_a), .rom_addr(rom_addr_a),
        .rom_read_en(rd_en_a), .rom_instr(rom_instr_a), .ir_out(ir_out_a),
        .pc_out(pc_out_a), .pc_plus4(pc_plus4_a), .ir_valid(ir_valid_a),
        .ir_ready(ir_ready_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
        .fetch_err(fetch_err_a), .state_dbg(state_a)
    );

    instr_fetch_unit #(.ROM_LAT(3), .ROM_BYTES(128)) dut_b (
        .clk(clk), .rst(rst_b), .start_pc(start_pc_b), .rom_addr(rom_addr_b),
        .rom_read_en(rd_en_b), .rom_instr(rom_instr_b), .ir_out(ir_out_b),
        .pc_out(pc_out_b), .pc_plus4(pc_plus4_b), .ir_valid(ir_valid_b),
        .ir_ready(ir_ready_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .fetch_err(fetch_err_b), .state_dbg(state_b)
    );

    // Clock and ROM image
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + 32'(i);
        rom[0] = 32'h2008_0005;
        rom[1] = 32'h2109_0003;
    end

    always_comb rom_instr_a = rom[rom_addr_a[6:2]];
    always_comb rom_instr_b = rom[rom_addr_b[6:2]];

    // Driver / check helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_a();
        check("a_rst_ir", ir_out_a, 32'h0);
        check("a_rst_pc_out", pc_out_a, 32'h0);
        check("a_rst_valid", 32'(ir_valid_a), 32'h0);
        check("a_rst_rd_en", 32'(rd_en_a), 32'h0);
        check("a_rst_err", 32'(fetch_err_a), 32'h0);
        check("a_rst_addr", rom_addr_a, 32'h0);
        check("a_rst_state", 32'(state_a), 32'h0);
    endtask

    // Scoreboard monitors: pop one expected {pc, ir} per handshake
    always @(negedge clk) begin
        if (!rst_a && ir_valid_a && ir_ready_a) begin
            if (exp_qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_ir: got pc %h ir %h expected none", pc_out_a, ir_out_a);
            end else begin
                ea = exp_qa.pop_front();
                check("a_mon_pc", pc_out_a, ea[63:32]);
                check("a_mon_ir", ir_out_a, ea[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && ir_valid_b && ir_ready_b) begin
            if (exp_qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_ir: got pc %h ir %h expected none", pc_out_b, ir_out_b);
            end else begin
                eb = exp_qb.pop_front();
                check("b_mon_pc", pc_out_b, eb[63:32]);
                check("b_mon_ir", ir_out_b, eb[31:0]);
            end
        end
    end

    // Stimulus
    initial begin
        rst_a = 1'b1; start_pc_a = 32'h0; ir_ready_a = 1'b1; redirect_a = 1'b0; redirect_pc_a = 32'h0;
        rst_b = 1'b1; start_pc_b = 32'h0; ir_ready_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = 32'h0;

        // Reset values
        tick(2);
        check_reset_a();
        check("a_rst_pc_plus4", pc_plus4_a, 32'h4);

        // T1: two sequential fetches from 0
        exp_qa.push_back({32'h0, 32'h2008_0005});
        exp_qa.push_back({32'h4, 32'h2109_0003});
        rst_a = 1'b0;
        tick(1);
        check("t1_valid_c1", 32'(ir_valid_a), 32'h0);
        check("t1_rd_en_c1", 32'(rd_en_a), 32'h1);
        check("t1_addr_c1", rom_addr_a, 32'h0);
        tick(1);
        check("t1_valid_c2", 32'(ir_valid_a), 32'h1);
        check("t1_pc_plus4", pc_plus4_a, 32'h4);
        tick(3);

        // T2: decode stalls 5 cycles on the word at 0x8
        ir_ready_a = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_ir", ir_out_a, 32'hA000_0002);
            check("t2_hold_pc", pc_out_a, 32'h8);
            check("t2_hold_rd_en", 32'(rd_en_a), 32'h0);
            check("t2_hold_valid", 32'(ir_valid_a), 32'h1);
            tick(1);
        end
        exp_qa.push_back({32'h8, 32'hA000_0002});
        ir_ready_a = 1'b1;
        tick(1);
        ir_ready_a = 1'b0;
        check("t2_refetch_rd_en", 32'(rd_en_a), 32'h1);
        check("t2_refetch_addr", rom_addr_a, 32'hC);
        tick(1);
        check("t2_next_pc", pc_out_a, 32'hC);
        check("t2_next_rd_en", 32'(rd_en_a), 32'h0);
        tick(2);
        check("t2_one_fetch_valid", 32'(ir_valid_a), 32'h1);
        check("t2_one_fetch_pc", pc_out_a, 32'hC);
        check("t2_one_fetch_rd_en", 32'(rd_en_a), 32'h0);

        // T3a: redirect to 0x40 while holding with ready high
        exp_qa.push_back({32'hC, 32'hA000_0003});
        exp_qa.push_back({32'h40, 32'hA000_0010});
        ir_ready_a = 1'b1; redirect_a = 1'b1; redirect_pc_a = 32'h40;
        tick(1);
        redirect_a = 1'b0;
        check("t3_redir_addr", rom_addr_a, 32'h40);
        check("t3_redir_rd_en", 32'(rd_en_a), 32'h1);
        tick(2);
        ir_ready_a = 1'b0;
        tick(1);
        check("t3_seq_pc", pc_out_a, 32'h44);
        check("t3_seq_ir", ir_out_a, 32'hA000_0011);

        // Redirect with ready low discards the word at 0x44
        redirect_a = 1'b1; redirect_pc_a = 32'h10;
        tick(1);
        redirect_a = 1'b0;
        check("t3_discard_valid", 32'(ir_valid_a), 32'h0);
        check("t3_discard_addr", rom_addr_a, 32'h10);
        exp_qa.push_back({32'h10, 32'hA000_0004});
        ir_ready_a = 1'b1;
        tick(1);

        // T4: misaligned redirect target
        redirect_a = 1'b1; redirect_pc_a = 32'h42;
        tick(1);
        redirect_a = 1'b0;
        check("t4_err", 32'(fetch_err_a), 32'h1);
        check("t4_valid", 32'(ir_valid_a), 32'h0);
        check("t4_rd_en", 32'(rd_en_a), 32'h0);
        tick(3);
        check("t4_err_sticky", 32'(fetch_err_a), 32'h1);
        check("t4_rd_en_sticky", 32'(rd_en_a), 32'h0);
        check("t4_state", 32'(state_a), 32'h3);

        // T5: last ROM word, then fault instead of fetching 0x80
        rst_a = 1'b1; start_pc_a = 32'h7C;
        tick(1);
        check_reset_a();
        exp_qa.push_back({32'h7C, 32'hA000_001F});
        rst_a = 1'b0;
        tick(1);
        check("t5_rd_en", 32'(rd_en_a), 32'h1);
        check("t5_addr", rom_addr_a, 32'h7C);
        tick(1);
        check("t5_valid", 32'(ir_valid_a), 32'h1);
        check("t5_pc_plus4", pc_plus4_a, 32'h80);
        tick(1);
        check("t5_err", 32'(fetch_err_a), 32'h1);
        check("t5_no_rom_access", 32'(rd_en_a), 32'h0);
        tick(2);
        check("t5_no_rom_access_later", 32'(rd_en_a), 32'h0);
        check("t5_err_sticky", 32'(fetch_err_a), 32'h1);

        // ROM_LAT = 3: first fetch latency and address hold
        exp_qb.push_back({32'h0, 32'h2008_0005});
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("b_req_rd_en", 32'(rd_en_b), 32'h1);
            check("b_req_addr", rom_addr_b, 32'h0);
            check("b_req_valid", 32'(ir_valid_b), 32'h0);
        end
        tick(1);
        check("b_first_valid", 32'(ir_valid_b), 32'h1);
        tick(1);
        check("b_second_addr", rom_addr_b, 32'h4);
        tick(1);

        // T3b: redirect in the middle of a ROM request
        exp_qb.push_back({32'h40, 32'hA000_0010});
        redirect_b = 1'b1; redirect_pc_b = 32'h40;
        tick(1);
        redirect_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3b_addr_hold", rom_addr_b, 32'h40);
            check("t3b_rd_en_hold", 32'(rd_en_b), 32'h1);
            check("t3b_valid_low", 32'(ir_valid_b), 32'h0);
            tick(1);
        end
        check("t3b_valid", 32'(ir_valid_b), 32'h1);
        tick(1);

        // T6: reset during the second request cycle of the fetch at 0x44
        tick(1);
        rst_b = 1'b1; start_pc_b = 32'h8;
        tick(1);
        check("t6_rst_ir", ir_out_b, 32'h0);
        check("t6_rst_pc_out", pc_out_b, 32'h0);
        check("t6_rst_pc_plus4", pc_plus4_b, 32'h4);
        check("t6_rst_valid", 32'(ir_valid_b), 32'h0);
        check("t6_rst_rd_en", 32'(rd_en_b), 32'h0);
        check("t6_rst_err", 32'(fetch_err_b), 32'h0);
        check("t6_rst_addr", rom_addr_b, 32'h0);
        exp_qb.push_back({32'h8, 32'hA000_0002});
        rst_b = 1'b0;
        tick(1);
        check("t6_restart_addr", rom_addr_b, 32'h8);
        check("t6_restart_rd_en", 32'(rd_en_b), 32'h1);
        tick(3);
        check("t6_restart_valid", 32'(ir_valid_b), 32'h1);
        tick(2);

        // Final report
        check("a_queue_drained", 32'(exp_qa.size()), 32'h0);
        check("b_queue_drained", 32'(exp_qb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
